ddr_port_arbiter: RTL and testbench
===================================

// Module: ddr_port_arbiter
// PURPOSE
//  Shares the single Avalon-MM burst port into the DDR3 controller between the conv engine's
//  feature-fetch reader (port 0, read-only) and result writer (port 1, write-only). Round-robin
//  grant with burst lock; tracks outstanding read beats and returns read data to port 0.
//  Sits between the conv engine and the NiosIISystem SDRAM slave.
// PARAMETERS
//  AW        29  Avalon word-address width
//  DW        32  data width (byteenable = DW/8, always all-ones)
//  BW        4   burstcount width; legal bursts 1..MAX_BURST
//  MAX_BURST 8   largest burst issued
//  MAX_OUT   16  max outstanding read beats (limit for the counter)
// PORTS
//  pll_ref_clk       in   1          clock; all logic rising-edge
//  global_reset_n    in   1          asynchronous active-low reset
//  rd_req            in   1          read burst request, hold until rd_gnt
//  rd_addr           in   AW         read start address
//  rd_burst          in   BW         read beats (0 treated as 1)
//  rd_gnt            out  1          1-cycle pulse: read command accepted by DDR
//  rd_data           out  DW         returned read beat
//  rd_data_valid     out  1          rd_data valid; no backpressure, client must sink
//  wr_req            in   1          write burst request, hold until first beat accepted
//  wr_addr           in   AW         write start address
//  wr_burst          in   BW         write beats (0 treated as 1)
//  wr_data           in   DW         current write beat; advance after wr_data_ready
//  wr_data_ready     out  1          beat accepted this cycle
//  wr_done           out  1          1-cycle pulse with last beat accepted
//  avm_address       out  AW         |
//  avm_read          out  1          |
//  avm_write         out  1          | Avalon-MM burst master
//  avm_burstcount    out  BW         |
//  avm_writedata     out  DW         |
//  avm_byteenable    out  DW/8       |
//  avm_waitrequest   in   1          |
//  avm_readdata      in   DW         |
//  avm_readdatavalid in   1          |
//  outstanding       out  5          read beats in flight (ceil(log2(MAX_OUT+1)))
//  busy              out  1          state != IDLE or outstanding != 0
//  err_underflow     out  1          sticky: readdatavalid while outstanding==0
// BEHAVIOUR
//  Reset (async, any time): state IDLE, outstanding=0, last_gnt=port1 (port 0 wins first tie),
//   err_underflow=0, all avm_* strobes 0, address/burstcount 0, rd_gnt/wr_data_ready/wr_done 0.
//   In-flight bursts are abandoned; no replay.
//  FSM IDLE -> RD_CMD | WR_BURST -> IDLE.
//  IDLE: rd eligible = rd_req && outstanding+eff_rd_burst <= MAX_OUT. If both eligible, grant
//   the port opposite last_gnt; otherwise grant the eligible one. Address and burst are latched
//   into registers on grant. avm_* asserted from the next cycle (1-cycle grant latency).
//  RD_CMD: avm_read=1 held with constant address/burstcount until !avm_waitrequest. That cycle:
//   rd_gnt=1, outstanding += burst, -> IDLE, last_gnt=0.
//  WR_BURST: avm_write=1, avm_writedata=wr_data, address/burstcount constant for all beats.
//   Each cycle with !avm_waitrequest: wr_data_ready=1, beat counter++. On the last beat: wr_done=1,
//   -> IDLE, last_gnt=1. No write bubbles; the client must present a valid wr_data every cycle.
//  Reads may be outstanding while a write burst runs; readdatavalid is always forwarded to
//   port 0 (rd_data=avm_readdata, rd_data_valid=avm_readdatavalid, combinational).
//  outstanding: +burst on read accept, -1 per readdatavalid; both in one cycle -> +burst-1.
//   Saturates at 0 on underflow and sets err_underflow.
//  burst > MAX_BURST is clamped to MAX_BURST. burst 0 is issued as 1.
//  Back-to-back: min 1 IDLE cycle between commands (sustained writes: 8 beats per 9+ cycles).
// TESTING
//  Single read burst 4 @0x100, waitreq 2 cycles -> avm_read 3 cycles, rd_gnt 1 pulse,
//   outstanding 4 -> 0 after 4 readdatavalid beats.
//  Both ports request continuously -> grants alternate rd,wr,rd,wr; first grant is rd.
//  Write burst 8 with waitrequest on beats 3 and 6 -> exactly 8 wr_data_ready, address/burst
//   stable throughout, wr_done on beat 8.
//  Outstanding=14, rd_burst=4 -> rd blocked, wr granted; after 2 readdatavalid, rd is granted.
//  Accept and readdatavalid in the same cycle: outstanding 3, burst 4 -> 6.
//  Assert reset mid write burst (beat 5) -> all strobes 0 asynchronously, IDLE, outstanding 0;
//   a stray readdatavalid afterwards sets err_underflow.

Source files
------------

// File: rtl/ddr_port_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM burst port between a read
// client and a write client, with burst lock and read-beat tracking.
module ddr_port_arbiter #(
   parameter int AW        = 29,
   parameter int DW        = 32,
   parameter int BW        = 4,
   parameter int MAX_BURST = 8,
   parameter int MAX_OUT   = 16,
   parameter int OW        = $clog2(MAX_OUT + 1)
) (
   input  logic            pll_ref_clk,
   input  logic            global_reset_n,
   input  logic            rd_req,
   input  logic [AW-1:0]   rd_addr,
   input  logic [BW-1:0]   rd_burst,
   output logic            rd_gnt,
   output logic [DW-1:0]   rd_data,
   output logic            rd_data_valid,
   input  logic            wr_req,
   input  logic [AW-1:0]   wr_addr,
   input  logic [BW-1:0]   wr_burst,
   input  logic [DW-1:0]   wr_data,
   output logic            wr_data_ready,
   output logic            wr_done,
   output logic [AW-1:0]   avm_address,
   output logic            avm_read,
   output logic            avm_write,
   output logic [BW-1:0]   avm_burstcount,
   output logic [DW-1:0]   avm_writedata,
   output logic [DW/8-1:0] avm_byteenable,
   input  logic            avm_waitrequest,
   input  logic [DW-1:0]   avm_readdata,
   input  logic            avm_readdatavalid,
   output logic [OW-1:0]   outstanding,
   output logic            busy,
   output logic            err_underflow
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_WR   = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [OW-1:0] out_q, out_d;
   logic          last_q, last_d;
   logic          err_q, err_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [BW-1:0] burst_q, burst_d;
   logic [BW-1:0] beat_q, beat_d;

   logic [BW-1:0] rd_eff, wr_eff;
   logic [OW:0]   rd_sum, out_sum, out_dec;
   logic          rd_ok, gnt_rd, gnt_wr;
   logic          rd_acc, wr_acc, wr_last;

   function automatic logic [BW-1:0] eff(input logic [BW-1:0] b);
      if (b == '0) return BW'(1);
      else if (int'(b) > MAX_BURST) return BW'(MAX_BURST);
      else return b;
   endfunction

   assign rd_eff = eff(rd_burst);
   assign wr_eff = eff(wr_burst);
   assign rd_sum = (OW+1)'(out_q) + (OW+1)'(rd_eff);
   assign rd_ok  = rd_req && (int'(rd_sum) <= MAX_OUT);

   assign rd_acc  = (state_q == S_RD) && !avm_waitrequest;
   assign wr_acc  = (state_q == S_WR) && !avm_waitrequest;
   assign wr_last = wr_acc && (beat_q == burst_q - BW'(1));

   // Tie goes to the port that did not win last; last_q=1 means port 1
   assign gnt_rd = (state_q == S_IDLE) && rd_ok && (!wr_req || last_q);
   assign gnt_wr = (state_q == S_IDLE) && wr_req && !gnt_rd;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      addr_d  = addr_q;
      burst_d = burst_q;
      beat_d  = beat_q;
      case (state_q)
         S_IDLE: begin
            if (gnt_rd) begin
               state_d = S_RD;
               addr_d  = rd_addr;
               burst_d = rd_eff;
            end else if (gnt_wr) begin
               state_d = S_WR;
               addr_d  = wr_addr;
               burst_d = wr_eff;
               beat_d  = '0;
            end
         end
         S_RD: begin
            if (rd_acc) begin
               state_d = S_IDLE;
               last_d  = 1'b0;
            end
         end
         S_WR: begin
            if (wr_acc) begin
               beat_d = beat_q + BW'(1);
               if (wr_last) begin
                  state_d = S_IDLE;
                  last_d  = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign out_sum = (OW+1)'(out_q) +
                    (rd_acc ? (OW+1)'(burst_q) : '0);
   assign out_dec = out_sum - (OW+1)'(1);

   // A beat arriving with nothing in flight is flagged, not counted
   always_comb begin
      err_d = err_q;
      out_d = out_sum[OW-1:0];
      if (avm_readdatavalid) begin
         if (out_q == '0) err_d = 1'b1;
         else out_d = out_dec[OW-1:0];
      end
   end

   always_ff @(posedge pll_ref_clk or negedge global_reset_n) begin
      if (!global_reset_n) begin
         state_q <= S_IDLE;
         out_q   <= '0;
         last_q  <= 1'b1;
         err_q   <= 1'b0;
         addr_q  <= '0;
         burst_q <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         last_q  <= last_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         burst_q <= burst_d;
         beat_q  <= beat_d;
      end
   end

   assign avm_read       = (state_q == S_RD);
   assign avm_write      = (state_q == S_WR);
   assign avm_address    = addr_q;
   assign avm_burstcount = burst_q;
   assign avm_writedata  = wr_data;
   assign avm_byteenable = '1;
   assign rd_gnt         = rd_acc;
   assign wr_data_ready  = wr_acc;
   assign wr_done        = wr_last;
   assign rd_data        = avm_readdata;
   assign rd_data_valid  = avm_readdatavalid;
   assign outstanding    = out_q;
   assign busy           = (state_q != S_IDLE) || (out_q != '0);
   assign err_underflow  = err_q;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Scoreboard bench for ddr_port_arbiter: stimulus queues expected
// commands and read beats, a negedge monitor checks them.
module tb_ddr_port_arbiter;

   typedef struct packed {
      logic        wr;
      logic [28:0] addr;
      logic [3:0]  burst;
      logic [31:0] dbase;
   } cmd_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rd_req = 1'b0;
   logic [28:0] rd_addr = '0;
   logic [3:0]  rd_burst = '0;
   logic        rd_gnt;
   logic [31:0] rd_data;
   logic        rd_data_valid;
   logic        wr_req = 1'b0;
   logic [28:0] wr_addr = '0;
   logic [3:0]  wr_burst = '0;
   logic [31:0] wr_data = '0;
   logic        wr_data_ready;
   logic        wr_done;
   logic [28:0] avm_address;
   logic        avm_read;
   logic        avm_write;
   logic [3:0]  avm_burstcount;
   logic [31:0] avm_writedata;
   logic [3:0]  avm_byteenable;
   logic        avm_waitrequest = 1'b0;
   logic [31:0] avm_readdata = '0;
   logic        avm_readdatavalid = 1'b0;
   logic [4:0]  outstanding;
   logic        busy;
   logic        err_underflow;

   int vectors = 0;
   int fails = 0;
   cmd_t cmd_q[$];
   logic [31:0] rdq[$];

   ddr_port_arbiter dut (
      .pll_ref_clk(clk),
      .global_reset_n(rst_n),
      .rd_req(rd_req),
      .rd_addr(rd_addr),
      .rd_burst(rd_burst),
      .rd_gnt(rd_gnt),
      .rd_data(rd_data),
      .rd_data_valid(rd_data_valid),
      .wr_req(wr_req),
      .wr_addr(wr_addr),
      .wr_burst(wr_burst),
      .wr_data(wr_data),
      .wr_data_ready(wr_data_ready),
      .wr_done(wr_done),
      .avm_address(avm_address),
      .avm_read(avm_read),
      .avm_write(avm_write),
      .avm_burstcount(avm_burstcount),
      .avm_writedata(avm_writedata),
      .avm_byteenable(avm_byteenable),
      .avm_waitrequest(avm_waitrequest),
      .avm_readdata(avm_readdata),
      .avm_readdatavalid(avm_readdatavalid),
      .outstanding(outstanding),
      .busy(busy),
      .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   task automatic flag(input string n, input string why);
      vectors++;
      fails++;
      $display("FAIL %s: %s", n, why);
   endtask

   function automatic logic [3:0] eff(input logic [3:0] b);
      if (b == 4'd0) return 4'd1;
      if (b > 4'd8) return 4'd8;
      return b;
   endfunction

   function automatic logic [31:0] dbase(input logic [28:0] a);
      return 32'hA500_0000 ^ {3'b000, a};
   endfunction

   function automatic cmd_t mk(input logic w, input logic [28:0] a,
                               input logic [3:0] b);
      cmd_t c;
      c.wr = w;
      c.addr = a;
      c.burst = eff(b);
      c.dbase = dbase(a);
      return c;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rdv(input logic [31:0] d);
      avm_readdatavalid = 1'b1;
      avm_readdata = d;
      rdq.push_back(d);
      tick();
      avm_readdatavalid = 1'b0;
   endtask

   task automatic drain(input int n, input logic [31:0] seed);
      for (int k = 0; k < n; k++) rdv(seed + k);
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      rd_req = 1'b0;
      wr_req = 1'b0;
      avm_waitrequest = 1'b0;
      avm_readdatavalid = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic do_read(input logic [28:0] a, input logic [3:0] b,
                          input int nwait, input bit rdv_acc,
                          input logic [31:0] rd_d);
      int reads = 0;
      bit got = 0;
      cmd_q.push_back(mk(1'b0, a, b));
      rd_req = 1'b1;
      rd_addr = a;
      rd_burst = b;
      for (int i = 0; i < 40 && !got; i++) begin
         tick();
         if (avm_read) begin
            reads++;
            avm_waitrequest = (reads <= nwait);
            if (!avm_waitrequest && rdv_acc) begin
               avm_readdatavalid = 1'b1;
               avm_readdata = rd_d;
               rdq.push_back(rd_d);
            end
            #1;
            got = rd_gnt;
         end
      end
      if (!got) flag("rd_gnt_wait", "timed out");
      tick();
      rd_req = 1'b0;
      avm_waitrequest = 1'b0;
      avm_readdatavalid = 1'b0;
      chk("rd_cmd_cycles", reads, nwait + 1);
   endtask

   task automatic do_write(input logic [28:0] a, input logic [3:0] b,
                           input logic [15:0] stall, input int abort);
      int beat = 0;
      bit done = 0;
      bit stalled = 0;
      logic [31:0] base;
      base = dbase(a);
      cmd_q.push_back(mk(1'b1, a, b));
      wr_req = 1'b1;
      wr_addr = a;
      wr_burst = b;
      wr_data = base;
      for (int i = 0; i < 60 && !done; i++) begin
         tick();
         wr_data = base + beat;
         if (beat > 0) wr_req = 1'b0;
         if (avm_write) begin
            if (abort >= 0 && beat == abort) return;
            avm_waitrequest = stall[beat] && !stalled;
            stalled = avm_waitrequest;
            #1;
            if (stalled) begin
               chk("wr_addr_stall", avm_address, a);
               chk("wr_burst_stall", avm_burstcount, eff(b));
            end
            if (wr_data_ready) begin
               beat++;
               done = wr_done;
            end
         end
      end
      if (!done) flag("wr_done_wait", "timed out");
      tick();
      wr_req = 1'b0;
      avm_waitrequest = 1'b0;
      chk("wr_beats", beat, eff(b));
   endtask

   initial begin : monitor
      cmd_t cr;
      cmd_t cw;
      int wbeat;
      wbeat = 0;
      cw = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            wbeat = 0;
         end else begin
            if (rd_data_valid) begin
               if (rdq.size() == 0) flag("rd_data", "unexpected beat");
               else chk("rd_data", rd_data, rdq.pop_front());
            end
            if (rd_gnt) begin
               if (cmd_q.size() == 0) flag("rd_gnt", "unexpected grant");
               else begin
                  cr = cmd_q.pop_front();
                  chk("gnt_is_rd", {31'd0, cr.wr}, 32'd0);
                  chk("rd_avm_addr", avm_address, cr.addr);
                  chk("rd_avm_burst", avm_burstcount, cr.burst);
               end
            end
            if (wr_data_ready) begin
               if (wbeat == 0) begin
                  if (cmd_q.size() == 0) flag("wr_beat", "unexpected beat");
                  else begin
                     cw = cmd_q.pop_front();
                     chk("gnt_is_wr", {31'd0, cw.wr}, 32'd1);
                  end
               end
               chk("wr_avm_addr", avm_address, cw.addr);
               chk("wr_avm_burst", avm_burstcount, cw.burst);
               chk("wr_avm_data", avm_writedata, cw.dbase + wbeat);
               chk("wr_done", wr_done, (wbeat == int'(cw.burst) - 1));
               if (wbeat == int'(cw.burst) - 1) wbeat = 0;
               else wbeat++;
            end
         end
      end
   end

   initial begin : stim
      int n;
      tick();
      chk("rst_read", avm_read, 0);
      chk("rst_write", avm_write, 0);
      chk("rst_addr", avm_address, 0);
      chk("rst_burst", avm_burstcount, 0);
      chk("rst_gnt", rd_gnt, 0);
      chk("rst_wready", wr_data_ready, 0);
      chk("rst_wdone", wr_done, 0);
      chk("rst_out", outstanding, 0);
      chk("rst_err", err_underflow, 0);
      chk("rst_be", avm_byteenable, 4'hF);
      reset_dut();
      chk("idle_busy", busy, 0);

      // both ports requesting from reset: rd, wr, rd, wr
      cmd_q.push_back(mk(1'b0, 29'h40, 4'd1));
      cmd_q.push_back(mk(1'b1, 29'h80, 4'd1));
      cmd_q.push_back(mk(1'b0, 29'h40, 4'd1));
      cmd_q.push_back(mk(1'b1, 29'h80, 4'd1));
      rd_req = 1'b1; rd_addr = 29'h40; rd_burst = 4'd1;
      wr_req = 1'b1; wr_addr = 29'h80; wr_burst = 4'd1;
      wr_data = dbase(29'h80);
      n = 0;
      for (int i = 0; i < 40 && n < 4; i++) begin
         tick();
         #1;
         if (rd_gnt || wr_done) n++;
      end
      if (n < 4) flag("alternate", "timed out");
      tick();
      rd_req = 1'b0;
      wr_req = 1'b0;
      chk("alt_out", outstanding, 2);
      drain(2, 32'h1000);

      // single read burst 4 with two waitrequest cycles
      do_read(29'h100, 4'd4, 2, 0, 0);
      chk("rd4_out", outstanding, 4);
      chk("rd4_busy", busy, 1);
      for (int k = 0; k < 4; k++) begin
         rdv(32'h2000 + k);
         chk("rd4_dec", outstanding, 3 - k);
      end
      chk("rd4_idle", busy, 0);

      // write burst 8, stalls on beats 3 and 6
      do_write(29'h2000, 4'd8, 16'b0000_0000_0010_0100, -1);

      // burst clamping
      do_read(29'h300, 4'd12, 1, 0, 0);
      chk("clamp_out", outstanding, 8);
      drain(8, 32'h3000);
      do_write(29'h310, 4'd0, 16'h0000, -1);

      // outstanding limit blocks read, write goes first
      do_read(29'h400, 4'd8, 0, 0, 0);
      do_read(29'h410, 4'd6, 0, 0, 0);
      chk("lim_out14", outstanding, 14);
      do_write(29'h600, 4'd1, 16'h0000, -1);
      rd_req = 1'b1; rd_addr = 29'h500; rd_burst = 4'd4;
      do_write(29'h700, 4'd2, 16'h0000, -1);
      for (int k = 0; k < 3; k++) begin
         chk("lim_blocked", avm_read, 0);
         tick();
      end
      chk("lim_hold", outstanding, 14);
      rdv(32'h4000);
      rdv(32'h4001);
      chk("lim_out12", outstanding, 12);
      do_read(29'h500, 4'd4, 0, 0, 0);
      chk("lim_out16", outstanding, 16);
      drain(16, 32'h4100);
      chk("lim_drained", outstanding, 0);

      // accept and readdatavalid together
      do_read(29'hA00, 4'd3, 0, 0, 0);
      do_read(29'hA10, 4'd4, 1, 1, 32'hC0DE);
      chk("same_cyc_out", outstanding, 6);
      drain(6, 32'h5000);

      // reset during beat 5 of a write
      do_read(29'h800, 4'd2, 0, 0, 0);
      do_write(29'h900, 4'd8, 16'h0000, 4);
      chk("mid_write", avm_write, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("ar_write", avm_write, 0);
      chk("ar_wready", wr_data_ready, 0);
      chk("ar_wdone", wr_done, 0);
      chk("ar_read", avm_read, 0);
      chk("ar_out", outstanding, 0);
      chk("ar_busy", busy, 0);
      avm_waitrequest = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_err", err_underflow, 0);
      rdv(32'h5757);
      chk("stray_err", err_underflow, 1);
      chk("stray_out", outstanding, 0);
      tick();
      chk("err_sticky", err_underflow, 1);

      tick();
      chk("cmd_q_empty", cmd_q.size(), 0);
      chk("rdq_empty", rdq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
